// File: rtl/primo_pkg.sv
// Shared definitions for the prime scanner.
//   W           - candidate width (fixed at 4 to match primo)
//   CW          - prime count width
//   PRIMES_0_15 - number of primes in 0..15
//   state_e     - scanner FSM state encoding
package primo_pkg;

  localparam int unsigned W           = 4;
  localparam int unsigned CW          = 3;
  localparam int unsigned PRIMES_0_15 = 6;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StEmit,
    StDone
  } state_e;

endpackage

// File: rtl/primo.sv
// Combinational prime detector for a 4-bit value.
//   N - candidate value
//   F - high when N is prime
module primo (
  input  logic [3:0] N,
  output logic       F
);

  always_comb begin
    F = 1'b0;
    case (N)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: F = 1'b1;
      default:                              F = 1'b0;
    endcase
  end

endmodule

// File: rtl/primo_scanner.sv
// Sweeps the inclusive range [lo, hi] through primo, one candidate per cycle, and streams
// each prime out over a valid/ready interface. A one-cycle done pulse ends each scan and
// count then holds the number of primes the consumer accepted.
//   clk, rst  - clock, synchronous active-high reset
//   start     - begin a scan (sampled only when idle)
//   lo, hi    - range bounds, latched on an accepted start
//   busy      - high whenever not idle
//   out_valid, out_ready, out_data - prime output stream
//   done      - one-cycle end-of-scan pulse
//   count     - primes accepted in the last scan
module primo_scanner
  import primo_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  lo,
  input  logic [W-1:0]  hi,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          done,
  output logic [CW-1:0] count
);

  state_e         state_q;
  logic [W-1:0]   cur_q;
  logic [W-1:0]   hi_q;
  logic           out_valid_q;
  logic [W-1:0]   out_data_q;
  logic [CW-1:0]  count_q;
  logic           is_prime;

  primo u_primo (
    .N (cur_q),
    .F (is_prime)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      hi_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cur_q   <= lo;
            hi_q    <= hi;
            count_q <= '0;
            state_q <= (lo > hi) ? StDone : StCheck;
          end
        end
        StCheck: begin
          if (is_prime) begin
            out_data_q  <= cur_q;
            out_valid_q <= 1'b1;
            state_q     <= StEmit;
          end else if (cur_q == hi_q) begin
            state_q <= StDone;
          end else begin
            cur_q <= cur_q + W'(1);
          end
        end
        StEmit: begin
          if (out_ready) begin
            count_q     <= count_q + CW'(1);
            out_valid_q <= 1'b0;
            // Compare before incrementing so hi = 15 ends the scan without wrapping to 0.
            if (cur_q == hi_q) begin
              state_q <= StDone;
            end else begin
              cur_q   <= cur_q + W'(1);
              state_q <= StCheck;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_primo_scanner.sv
module tb_primo_scanner;
  import primo_pkg::*;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  lo;
  logic [W-1:0]  hi;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          done;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic         held;
  logic [W-1:0] held_data;

  primo_scanner dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lo        (lo),
    .hi        (hi),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: samples just after the negative edge, when inputs for the next posedge are settled.
  initial held = 1'b0;
  always @(negedge clk) begin
    #1;
    if (!rst && out_valid) begin
      if (held) check("data_stable", int'(out_data), int'(held_data));
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_emit", int'(out_data), -1);
        end else begin
          check("emit_data", int'(out_data), int'(exp_q.pop_front()));
        end
        held = 1'b0;
      end else begin
        held      = 1'b1;
        held_data = out_data;
      end
    end else begin
      held = 1'b0;
    end
  end

  // Issues a start and measures cycles to done. With poke set, a start with lo=hi=0 is
  // driven in cycle 2 of the scan and must be ignored.
  task automatic run_scan(input string name, input int l, input int h, input int exp_lat,
                          input int exp_cnt, input bit poke);
    int lat;
    @(negedge clk);
    start = 1'b1;
    lo    = W'(l);
    hi    = W'(h);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 2) begin
        start = 1'b1;
        lo    = '0;
        hi    = '0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({name, "_done_latency"}, lat, exp_lat);
    @(negedge clk);
    check({name, "_done_one_cycle"}, int'(done), 0);
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_count"}, int'(count), exp_cnt);
    check({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid_seen"}, int'(out_valid), 1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, int'(done), 1);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    lo        = '0;
    hi        = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(out_valid), 0);
    check("reset_data", int'(out_data), 0);
    check("reset_done", int'(done), 0);
    check("reset_count", int'(count), 0);
    rst = 1'b0;

    // Full range: 16 CHECK + 6 EMIT + 1 DONE.
    exp_q = '{4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13};
    run_scan("full", 0, 15, 23, PRIMES_0_15, 1'b0);

    // Single candidates.
    exp_q.push_back(4'd7);
    run_scan("single7", 7, 7, 3, 1, 1'b0);
    run_scan("single9", 9, 9, 2, 0, 1'b0);

    // Empty range goes straight to DONE.
    run_scan("empty", 9, 3, 1, 0, 1'b0);

    // Backpressure on 5: held four cycles, accepted on the fourth.
    exp_q.push_back(4'd5);
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b1;
    lo        = 4'd4;
    hi        = 4'd6;
    @(negedge clk);
    start = 1'b0;
    wait_valid("bp");
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_data", int'(out_data), 5);
      @(negedge clk);
    end
    check("bp_fourth_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", int'(out_valid), 0);
    wait_done("bp");
    check("bp_count", int'(count), 1);
    check("bp_queue_left", exp_q.size(), 0);

    // Reset while 2 is being presented.
    out_ready = 1'b0;
    start     = 1'b1;
    lo        = 4'd0;
    hi        = 4'd15;
    @(negedge clk);
    start = 1'b0;
    wait_valid("rst_mid");
    check("rst_mid_data", int'(out_data), 2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", int'(out_valid), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_count", int'(count), 0);
    check("rst_mid_data_clr", int'(out_data), 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    exp_q     = '{4'd11, 4'd13};
    run_scan("after_rst", 11, 15, 8, 2, 1'b0);

    // Start pulse while busy is ignored; scan ends at 15 without wrapping.
    exp_q.push_back(4'd13);
    run_scan("nowrap", 13, 15, 5, 1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
